// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter: sequencer states,
// RISC-V load/store funct3 encodings and the access legality check.
package dmem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_ADDR,
        LD_SAMPLE,
        ST_ADDR,
        ST_COMMIT,
        RESP,
        ERR
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned sub-word variants exist only for loads; alignment follows access size.
    function automatic logic access_ok(input logic write, input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !write;
            F3_H:    ok = !addr_lo[0];
            F3_HU:   ok = !write && !addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake plus memory-side bus of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ*3-1:0]      req_funct3;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;
    logic [ADDR_W-1:0]       mem_address;
    logic [DATA_W-1:0]       mem_write_data;
    logic [2:0]              mem_funct3;
    logic                    mem_write;
    logic                    mem_read;
    logic [DATA_W-1:0]       mem_read_data;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3, mem_read_data,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               mem_address, mem_write_data, mem_funct3, mem_write, mem_read
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3, mem_read_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               mem_address, mem_write_data, mem_funct3, mem_write, mem_read
    );
endinterface

// File: rtl/dmem_arbiter_rr.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves
// to one past the granted port only when that grant is actually taken.
module rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             enable,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] owner
);
    logic [IDX_W-1:0] ptr;
    logic             found;
    int               idx;

    always_comb begin
        grant = '0;
        owner = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                owner      = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: grants one requester at a time and walks each access
// through the BRAM wrapper's read latency and read-modify-write store path.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus,
    output logic          busy
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t            state, next_state;
    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  owner, lat_owner;
    logic              arb_enable, fire;
    logic              sel_write, lat_write;
    logic [ADDR_W-1:0] sel_addr, lat_addr;
    logic [DATA_W-1:0] sel_wdata, lat_wdata;
    logic [2:0]        sel_funct3, lat_funct3;

    // Grants open only in IDLE, and never while reset is held
    assign arb_enable = (state == IDLE) && rst_n;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_valid),
        .enable  (arb_enable),
        .advance (fire),
        .grant   (grant),
        .owner   (owner)
    );

    assign bus.req_ready = grant;
    assign fire          = |(grant & bus.req_valid);

    assign sel_write  = bus.req_write[owner];
    assign sel_addr   = bus.req_addr[owner*ADDR_W +: ADDR_W];
    assign sel_wdata  = bus.req_wdata[owner*DATA_W +: DATA_W];
    assign sel_funct3 = bus.req_funct3[owner*3 +: 3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_owner  <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_funct3 <= '0;
        end else begin
            state <= next_state;
            if (fire) begin
                lat_owner  <= owner;
                lat_write  <= sel_write;
                lat_addr   <= sel_addr;
                lat_wdata  <= sel_wdata;
                lat_funct3 <= sel_funct3;
            end
        end
    end

    // Bus fields come straight from the latched request so they stay put in IDLE
    assign bus.mem_address    = lat_addr;
    assign bus.mem_write_data = lat_wdata;
    assign bus.mem_funct3     = lat_funct3;
    assign busy               = (state != IDLE);

    always_comb begin
        next_state    = state;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        bus.rsp_err   = 1'b0;
        case (state)
            IDLE: begin
                if (fire) begin
                    if (!access_ok(sel_write, sel_funct3, sel_addr[1:0])) begin
                        next_state = ERR;
                    end else if (sel_write) begin
                        next_state = ST_ADDR;
                    end else begin
                        next_state = LD_ADDR;
                    end
                end
            end
            LD_ADDR:   next_state = LD_SAMPLE;
            LD_SAMPLE: begin
                bus.mem_read = 1'b1;
                next_state   = RESP;
            end
            // The wrapper fetches the old word here so sub-word stores can merge into it
            ST_ADDR:   next_state = ST_COMMIT;
            ST_COMMIT: begin
                bus.mem_write = 1'b1;
                next_state    = RESP;
            end
            RESP: begin
                bus.rsp_valid[lat_owner] = 1'b1;
                bus.rsp_data             = lat_write ? '0 : bus.mem_read_data;
                next_state               = IDLE;
            end
            ERR: begin
                bus.rsp_valid[lat_owner] = 1'b1;
                bus.rsp_err              = 1'b1;
                next_state               = IDLE;
            end
            default:   next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a word-array BRAM model on the memory
// side and a byte-level reference model that predicts grants and responses.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   wr_total = 0;
    int   rd_total = 0;
    int   rsp_total = 0;
    int   multi_ready = 0;
    int   ref_ptr = 0;
    logic [7:0] ref_bytes [256];

    dmem_arbiter_if #(.N_REQ(2), .ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM wrapper model: registered, extended read data and merged sub-word stores
    logic [31:0] mem_words [64];
    logic        mem_init;
    logic [5:0]  mem_idx;
    logic [4:0]  mem_sh;
    logic [31:0] mem_old, mem_raw, mem_merged, mem_ext;

    assign mem_idx = bus.mem_address[7:2];
    assign mem_sh  = {bus.mem_address[1:0], 3'b000};
    assign mem_old = mem_words[mem_idx];
    assign mem_raw = mem_old >> mem_sh;

    always_comb begin
        case (bus.mem_funct3[1:0])
            2'b00:   mem_merged = (mem_old & ~(32'h0000_00FF << mem_sh)) |
                                  ((bus.mem_write_data & 32'h0000_00FF) << mem_sh);
            2'b01:   mem_merged = (mem_old & ~(32'h0000_FFFF << mem_sh)) |
                                  ((bus.mem_write_data & 32'h0000_FFFF) << mem_sh);
            default: mem_merged = bus.mem_write_data;
        endcase
        case (bus.mem_funct3)
            F3_B:    mem_ext = {{24{mem_raw[7]}}, mem_raw[7:0]};
            F3_H:    mem_ext = {{16{mem_raw[15]}}, mem_raw[15:0]};
            F3_BU:   mem_ext = {24'h0, mem_raw[7:0]};
            F3_HU:   mem_ext = {16'h0, mem_raw[15:0]};
            default: mem_ext = mem_raw;
        endcase
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem_words[i] <= '0;
        end else begin
            if (bus.mem_write) mem_words[mem_idx] <= mem_merged;
            if (bus.mem_read)  bus.mem_read_data <= mem_ext;
        end
    end

    always @(negedge clk) begin
        if (bus.mem_write) wr_total <= wr_total + 1;
        if (bus.mem_read) rd_total <= rd_total + 1;
        if (|bus.rsp_valid) rsp_total <= rsp_total + 1;
        if ($countones(bus.req_ready) > 1) multi_ready <= multi_ready + 1;
    end

    // Reference model: legality, little-endian byte storage, sign/zero extension
    function automatic logic ref_ok(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        int  size = 1 << f3[1:0];
        logic legal;
        legal = wr ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return legal && ((addr % 32'(size)) == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
        int     size = 1 << f3[1:0];
        longint v = 0;
        for (int i = 0; i < size; i++) v += longint'(ref_bytes[int'(addr) + i]) << (8 * i);
        if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1))) v -= (longint'(1) << (8 * size));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wdata);
        int size = 1 << f3[1:0];
        for (int i = 0; i < size; i++) ref_bytes[int'(addr) + i] = 8'((wdata >> (8 * i)) & 32'hFF);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic timeoutFail(input string tag);
        checks++;
        failures++;
        $error("[TB] FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic applyStimulus(input int port, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] f3);
        bus.req_write[port]         = wr;
        bus.req_addr[port*32 +: 32] = addr;
        bus.req_wdata[port*32 +: 32] = wdata;
        bus.req_funct3[port*3 +: 3] = f3;
        bus.req_valid[port]         = 1'b1;
        #1;
    endtask

    task automatic issueRandom(input int port);
        applyStimulus(port, 1'($urandom % 2), 32'($urandom % 64), $urandom, 3'($urandom % 8));
    endtask

    // Waits for the next grant, then checks it and the resulting response
    task automatic serviceOne(input string tag, output int winner);
        int waited = 0;
        int exp_win = -1;
        int fire_cyc, wr0, rd0;
        logic        f_wr, exp_err;
        logic [31:0] f_addr, f_wdata, exp_data;
        logic [2:0]  f_f3;
        winner = -1;
        while (bus.req_ready == '0 && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        if (bus.req_ready == '0) begin
            timeoutFail({tag, "_grant_wait"});
            return;
        end
        for (int k = 0; k < 2; k++) begin
            int c = (ref_ptr + k) % 2;
            if (exp_win < 0 && bus.req_valid[c]) exp_win = c;
        end
        checkOutput({tag, "_grant"}, 32'(bus.req_ready), 32'(2'b01 << exp_win));
        winner   = bus.req_ready[1] ? 1 : 0;
        f_wr     = bus.req_write[winner];
        f_addr   = bus.req_addr[winner*32 +: 32];
        f_wdata  = bus.req_wdata[winner*32 +: 32];
        f_f3     = bus.req_funct3[winner*3 +: 3];
        exp_err  = !ref_ok(f_wr, f_f3, f_addr);
        exp_data = (f_wr || exp_err) ? 32'h0 : ref_load(f_addr, f_f3);
        fire_cyc = cyc;
        wr0      = wr_total;
        rd0      = rd_total;
        ref_ptr  = (winner + 1) % 2;
        @(negedge clk); #1;
        bus.req_valid[winner] = 1'b0;
        checkOutput({tag, "_busy"}, 32'(busy), 32'h1);
        waited = 0;
        while (bus.rsp_valid == '0 && waited < 10) begin
            @(negedge clk); #1;
            waited++;
        end
        if (bus.rsp_valid == '0) begin
            timeoutFail({tag, "_rsp_wait"});
            return;
        end
        checkOutput({tag, "_latency"}, 32'(cyc - fire_cyc), exp_err ? 32'd1 : 32'd3);
        checkOutput({tag, "_rsp_owner"}, 32'(bus.rsp_valid), 32'(2'b01 << winner));
        checkOutput({tag, "_rsp_data"}, bus.rsp_data, exp_data);
        checkOutput({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
        checkOutput({tag, "_wr_strobes"}, 32'(wr_total - wr0), (f_wr && !exp_err) ? 32'd1 : 32'd0);
        checkOutput({tag, "_rd_strobes"}, 32'(rd_total - rd0), (!f_wr && !exp_err) ? 32'd1 : 32'd0);
        if (f_wr && !exp_err) ref_store(f_addr, f_f3, f_wdata);
    endtask

    initial begin
        int w;
        int waited;
        int rsp0;
        rst_n          = 1'b0;
        mem_init       = 1'b1;
        bus.req_valid  = 2'b11;
        bus.req_write  = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_funct3 = '0;
        for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_mem_write", 32'(bus.mem_write), 32'h0);
        checkOutput("reset_mem_read", 32'(bus.mem_read), 32'h0);
        checkOutput("reset_mem_address", bus.mem_address, 32'h0);
        bus.req_valid = 2'b00;
        mem_init      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;

        $display("[TB] word store then load on port 0");
        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, F3_W);
        serviceOne("sw_10", w);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, F3_W);
        serviceOne("lw_10", w);

        $display("[TB] byte store merges into existing word");
        applyStimulus(0, 1'b1, 32'h10, 32'h11223344, F3_W);
        serviceOne("sw_11223344", w);
        applyStimulus(0, 1'b1, 32'h13, 32'hA5A5A55A, F3_B);
        serviceOne("sb_13", w);
        applyStimulus(0, 1'b0, 32'h13, 32'h0, F3_BU);
        serviceOne("lbu_13", w);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, F3_W);
        serviceOne("lw_merged", w);
        checkOutput("lw_merged_literal", bus.rsp_data, 32'h5A223344);

        $display("[TB] both ports continuously valid");
        applyStimulus(0, 1'b0, 32'h10, 32'h0, F3_W);
        applyStimulus(1, 1'b1, 32'h24, 32'hCAFEF00D, F3_W);
        for (int n = 0; n < 8; n++) begin
            serviceOne("alternate", w);
            if (w >= 0 && n < 6) issueRandom(w);
        end
        while (bus.req_valid != '0) serviceOne("alternate_drain", w);

        $display("[TB] misaligned and illegal accesses");
        applyStimulus(0, 1'b0, 32'h11, 32'h0, F3_H);
        serviceOne("lh_misaligned", w);
        applyStimulus(1, 1'b0, 32'h12, 32'h0, F3_W);
        serviceOne("lw_misaligned", w);
        applyStimulus(0, 1'b1, 32'h10, 32'h12345678, 3'b100);
        serviceOne("store_f3_100", w);

        $display("[TB] reset during store commit");
        applyStimulus(0, 1'b1, 32'h20, 32'h8001_1234, F3_W);
        serviceOne("sw_20", w);
        rsp0 = rsp_total;
        applyStimulus(0, 1'b1, 32'h20, 32'hFFFFFFFF, F3_W);
        waited = 0;
        while (!bus.req_ready[0] && waited < 20) begin @(negedge clk); #1; waited++; end
        @(negedge clk); #1;
        bus.req_valid[0] = 1'b0;
        waited = 0;
        while (!bus.mem_write && waited < 10) begin @(negedge clk); #1; waited++; end
        if (!bus.mem_write) timeoutFail("commit_wait");
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_mem_write", 32'(bus.mem_write), 32'h0);
        checkOutput("rst_mid_busy", 32'(busy), 32'h0);
        checkOutput("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        ref_ptr = 0;
        #1;
        checkOutput("rst_mid_no_rsp", 32'(rsp_total - rsp0), 32'h0);
        applyStimulus(0, 1'b0, 32'h20, 32'h0, F3_W);
        serviceOne("lw_20_after_reset", w);
        checkOutput("lw_20_literal", bus.rsp_data, 32'h8001_1234);

        $display("[TB] signed and unsigned halfword loads");
        applyStimulus(1, 1'b0, 32'h22, 32'h0, F3_H);
        serviceOne("lh_22", w);
        checkOutput("lh_22_literal", bus.rsp_data, 32'hFFFF8001);
        applyStimulus(0, 1'b0, 32'h22, 32'h0, F3_HU);
        serviceOne("lhu_22", w);
        checkOutput("lhu_22_literal", bus.rsp_data, 32'h00008001);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            if (bus.req_valid == '0) issueRandom(int'($urandom % 2));
            for (int p = 0; p < 2; p++) if (!bus.req_valid[p] && ($urandom % 2) == 1) issueRandom(p);
            serviceOne("rand", w);
        end
        while (bus.req_valid != '0) serviceOne("rand_drain", w);

        checkOutput("never_two_ready", 32'(multi_ready), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
